// File: rtl/paddle_engine.sv
// paddle_engine: button-driven vertical paddle positions with optional acceleration,
// plus a two-register pixel renderer for the playfield border and the paddles.
module paddle_engine #(
  parameter int NUM_PADDLES = 2,
  parameter int COORD_W     = 11,
  parameter int H_VISIBLE   = 1024,
  parameter int V_VISIBLE   = 768,
  parameter int BORDER      = 16,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 96,
  parameter int PADDLE_GAP  = 16,
  parameter int STEP_DIV    = 131072,
  parameter int ACCEL_MODE  = 0,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_SPEED   = 8
) (
  input  logic                           pixelClock,
  input  logic                           resetN,
  input  logic [COORD_W-1:0]             xPixel,
  input  logic [COORD_W-1:0]             yPixel,
  input  logic                           visible,
  input  logic                           frameStrobe,
  input  logic [NUM_PADDLES-1:0]         paddleUp,
  input  logic [NUM_PADDLES-1:0]         paddleDown,
  output logic [NUM_PADDLES*COORD_W-1:0] paddleTop,
  output logic [NUM_PADDLES-1:0]         paddleHit,
  output logic                           borderHit,
  output logic [23:0]                    pixelColor
);

  localparam int RANGE  = V_VISIBLE - 2 * BORDER - PADDLE_H;
  localparam int EXT_W  = COORD_W + 1;
  localparam int PRE_W  = $clog2(STEP_DIV);
  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  typedef enum logic [1:0] {MV_IDLE, MV_UP, MV_DOWN} mv_state_e;

  function automatic logic [COORD_W-1:0] sat_up(input logic [COORD_W-1:0] p,
                                                input logic [SPD_W-1:0] s);
    logic [EXT_W-1:0] diff;
    diff = {1'b0, p} - EXT_W'(s);
    return diff[COORD_W] ? '0 : diff[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] sat_dn(input logic [COORD_W-1:0] p,
                                                input logic [SPD_W-1:0] s);
    logic [EXT_W-1:0] sum;
    sum = {1'b0, p} + EXT_W'(s);
    return (sum > EXT_W'(RANGE)) ? COORD_W'(RANGE) : sum[COORD_W-1:0];
  endfunction

  // Paddle 0 sits at the right edge, paddle 1 at the left.
  function automatic int col_lo(input int i);
    return (i == 0) ? H_VISIBLE - BORDER - PADDLE_GAP - PADDLE_W : BORDER + PADDLE_GAP;
  endfunction

  function automatic logic [23:0] pixel_rgb(input logic vis, input logic border,
                                            input logic paddle);
    if (!vis)   return 24'h000000;
    if (border) return 24'h00FFFF;
    if (paddle) return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  logic [NUM_PADDLES-1:0] up_meta_q, up_meta_d, up_sync_q, up_sync_d;
  logic [NUM_PADDLES-1:0] dn_meta_q, dn_meta_d, dn_sync_q, dn_sync_d;
  logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic                   tick;

  logic [COORD_W-1:0] pos_q   [NUM_PADDLES];
  logic [COORD_W-1:0] pos_d   [NUM_PADDLES];
  logic [COORD_W-1:0] disp_q  [NUM_PADDLES];
  logic [COORD_W-1:0] disp_d  [NUM_PADDLES];
  logic [COORD_W-1:0] top_q   [NUM_PADDLES];
  logic [COORD_W-1:0] top_d   [NUM_PADDLES];
  logic [SPD_W-1:0]   speed_q [NUM_PADDLES];
  logic [SPD_W-1:0]   speed_d [NUM_PADDLES];
  logic [SPD_W-1:0]   step    [NUM_PADDLES];
  logic [HOLD_W-1:0]  hold_q  [NUM_PADDLES];
  logic [HOLD_W-1:0]  hold_d  [NUM_PADDLES];
  mv_state_e          state_q [NUM_PADDLES];
  mv_state_e          state_d [NUM_PADDLES];

  logic [EXT_W-1:0]       x_e, y_e, row_top;
  logic [NUM_PADDLES-1:0] hit_p1_q, hit_p1_d, paddle_hit_q, paddle_hit_d;
  logic                   border_p1_q, border_p1_d, vis_p1_q, vis_p1_d;
  logic                   border_hit_q, border_hit_d;
  logic [23:0]            color_q, color_d;

  assign tick = (pre_cnt_q == PRE_W'(STEP_DIV - 1));

  always_comb begin
    up_meta_d = paddleUp;
    up_sync_d = up_meta_q;
    dn_meta_d = paddleDown;
    dn_sync_d = dn_meta_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    for (int i = 0; i < NUM_PADDLES; i++) begin
      pos_d[i]   = pos_q[i];
      speed_d[i] = speed_q[i];
      hold_d[i]  = hold_q[i];
      state_d[i] = state_q[i];
      step[i]    = SPD_W'(1);
      disp_d[i]  = frameStrobe ? pos_q[i] : disp_q[i];
      top_d[i]   = COORD_W'(BORDER) + pos_q[i];
      if (tick) begin
        if (up_sync_q[i] == dn_sync_q[i]) begin
          speed_d[i] = SPD_W'(1);
          hold_d[i]  = '0;
          state_d[i] = MV_IDLE;
        end else begin
          if (ACCEL_MODE != 0) begin
            if (state_q[i] == (up_sync_q[i] ? MV_UP : MV_DOWN)) begin
              // The move on the tick that completes a hold period already uses the new speed.
              if (hold_q[i] == HOLD_W'(ACCEL_TICKS - 1)) begin
                hold_d[i] = '0;
                if (speed_q[i] < SPD_W'(MAX_SPEED)) speed_d[i] = speed_q[i] + SPD_W'(1);
              end else begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
              end
              step[i] = speed_d[i];
            end else begin
              state_d[i] = up_sync_q[i] ? MV_UP : MV_DOWN;
              hold_d[i]  = '0;
              speed_d[i] = SPD_W'(1);
            end
          end
          pos_d[i] = up_sync_q[i] ? sat_up(pos_q[i], step[i]) : sat_dn(pos_q[i], step[i]);
        end
      end
    end
  end

  // Stage 1: geometry comparisons against the frame-latched positions.
  always_comb begin
    x_e         = {1'b0, xPixel};
    y_e         = {1'b0, yPixel};
    row_top     = '0;
    vis_p1_d    = visible;
    border_p1_d = (x_e < EXT_W'(BORDER)) || (x_e >= EXT_W'(H_VISIBLE - BORDER)) ||
                  (y_e < EXT_W'(BORDER)) || (y_e >= EXT_W'(V_VISIBLE - BORDER));
    for (int i = 0; i < NUM_PADDLES; i++) begin
      row_top     = EXT_W'(BORDER) + {1'b0, disp_q[i]};
      hit_p1_d[i] = (x_e >= EXT_W'(col_lo(i))) && (x_e < EXT_W'(col_lo(i) + PADDLE_W)) &&
                    (y_e >= row_top) && (y_e < row_top + EXT_W'(PADDLE_H));
    end
  end

  // Stage 2: output hit flags and colour.
  always_comb begin
    paddle_hit_d = hit_p1_q;
    border_hit_d = border_p1_q;
    color_d      = pixel_rgb(vis_p1_q, border_p1_q, |hit_p1_q);
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      up_meta_q    <= '0;
      up_sync_q    <= '0;
      dn_meta_q    <= '0;
      dn_sync_q    <= '0;
      pre_cnt_q    <= '0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        pos_q[i]   <= COORD_W'(RANGE / 2);
        disp_q[i]  <= COORD_W'(RANGE / 2);
        top_q[i]   <= COORD_W'(BORDER + RANGE / 2);
        speed_q[i] <= SPD_W'(1);
        hold_q[i]  <= '0;
        state_q[i] <= MV_IDLE;
      end
      hit_p1_q     <= '0;
      border_p1_q  <= 1'b0;
      vis_p1_q     <= 1'b0;
      paddle_hit_q <= '0;
      border_hit_q <= 1'b0;
      color_q      <= '0;
    end else begin
      up_meta_q    <= up_meta_d;
      up_sync_q    <= up_sync_d;
      dn_meta_q    <= dn_meta_d;
      dn_sync_q    <= dn_sync_d;
      pre_cnt_q    <= pre_cnt_d;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        pos_q[i]   <= pos_d[i];
        disp_q[i]  <= disp_d[i];
        top_q[i]   <= top_d[i];
        speed_q[i] <= speed_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
      end
      hit_p1_q     <= hit_p1_d;
      border_p1_q  <= border_p1_d;
      vis_p1_q     <= vis_p1_d;
      paddle_hit_q <= paddle_hit_d;
      border_hit_q <= border_hit_d;
      color_q      <= color_d;
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_top
    assign paddleTop[g*COORD_W +: COORD_W] = top_q[g];
  end

  assign paddleHit  = paddle_hit_q;
  assign borderHit  = border_hit_q;
  assign pixelColor = color_q;

endmodule

// File: tb/tb_paddle_engine.sv
// Directed bench for paddle_engine: one fixed-speed instance and one accelerating
// instance share the pixel inputs; each has its own buttons.
module tb_paddle_engine;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [CW-1:0] x = '0, y = '0;
  logic          vis = 1'b0, fs = 1'b0;
  logic [1:0]    up_a = '0, dn_a = '0, up_b = '0, dn_b = '0;
  logic [2*CW-1:0] top_a, top_b;
  logic [1:0]    hit_a, hit_b;
  logic          bh_a, bh_b;
  logic [23:0]   col_a, col_b;

  int n_checks = 0;
  int n_err    = 0;

  paddle_engine #(.STEP_DIV(4), .ACCEL_MODE(0)) dut_a (
    .pixelClock(clk), .resetN(rst_n), .xPixel(x), .yPixel(y), .visible(vis),
    .frameStrobe(fs), .paddleUp(up_a), .paddleDown(dn_a), .paddleTop(top_a),
    .paddleHit(hit_a), .borderHit(bh_a), .pixelColor(col_a));

  paddle_engine #(.STEP_DIV(4), .ACCEL_MODE(1), .ACCEL_TICKS(2), .MAX_SPEED(4)) dut_b (
    .pixelClock(clk), .resetN(rst_n), .xPixel(x), .yPixel(y), .visible(vis),
    .frameStrobe(fs), .paddleUp(up_b), .paddleDown(dn_b), .paddleTop(top_b),
    .paddleHit(hit_b), .borderHit(bh_b), .pixelColor(col_b));

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [CW-1:0] get_top(input int sel);
    case (sel)
      0:       return top_a[CW-1:0];
      1:       return top_a[2*CW-1:CW];
      default: return top_b[CW-1:0];
    endcase
  endfunction

  // Present a pixel for one cycle, then blank; result is sampled two clocks later.
  task automatic probe(input int px, input int py, input logic pv);
    @(negedge clk);
    x = px[CW-1:0]; y = py[CW-1:0]; vis = pv;
    @(posedge clk);
    @(negedge clk);
    x = '0; y = '0; vis = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    @(negedge clk); fs = 1'b1;
    @(negedge clk); fs = 1'b0;
  endtask

  task automatic wait_change(input int sel, input logic [CW-1:0] prev,
                             output logic [CW-1:0] cur, output bit ok);
    ok  = 1'b0;
    cur = prev;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      cur = get_top(sel);
      if (cur != prev) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] prev, cur, old;
    bit ok;
    int d, changes, bad, peak;
    int accel_exp [8];
    int up_exp [5];
    accel_exp = '{1, 1, 2, 2, 3, 3, 4, 4};
    up_exp    = '{-1, -1, -2, -2, -3};

    // Reset state
    #22;
    check_val("rst_top0_a", get_top(0), 336);
    check_val("rst_top1_a", get_top(1), 336);
    check_val("rst_top0_b", get_top(2), 336);
    check_val("rst_col_a", col_a, 0);
    check_val("rst_hit_a", hit_a, 0);
    check_val("rst_border_a", bh_a, 0);
    @(negedge clk); rst_n = 1'b1;

    // Geometry and colour at the reset position
    strobe();
    probe(984, 336, 1'b1);
    check_val("px_984_336_col", col_a, 24'hFFFFFF);
    check_val("px_984_336_hit", hit_a, 2'b01);
    check_val("px_984_336_brd", bh_a, 0);
    probe(984, 431, 1'b1); check_val("px_last_row", col_a, 24'hFFFFFF);
    probe(984, 432, 1'b1); check_val("px_below", col_a, 24'h000000);
    probe(984, 335, 1'b1); check_val("px_above", col_a, 24'h000000);
    probe(40, 336, 1'b1);
    check_val("px_left_hit", hit_a, 2'b10);
    check_val("px_left_col", col_a, 24'hFFFFFF);
    probe(975, 400, 1'b1); check_val("px_x_left_of_p0", col_a, 24'h000000);
    probe(992, 400, 1'b1); check_val("px_x_right_of_p0", col_a, 24'h000000);
    probe(8, 100, 1'b1);
    check_val("px_border_col", col_a, 24'h00FFFF);
    check_val("px_border_flag", bh_a, 1);
    probe(1008, 500, 1'b1); check_val("px_right_border", bh_a, 1);
    probe(1007, 500, 1'b1); check_val("px_inside_right", bh_a, 0);
    probe(500, 752, 1'b1); check_val("px_bottom_border", col_a, 24'h00FFFF);
    probe(984, 400, 1'b0); check_val("px_invisible", col_a, 24'h000000);

    // Fixed speed: hold up on paddle 0 for ~400 ticks
    @(negedge clk); up_a = 2'b01;
    prev = get_top(0); changes = 0; bad = 0;
    for (int c = 0; c < 1620; c++) begin
      @(negedge clk);
      cur = get_top(0);
      if (cur != prev) begin
        changes++;
        if (int'(prev) - int'(cur) != 1) bad++;
        prev = cur;
      end
    end
    up_a = '0;
    check_val("up_move_count", changes, 320);
    check_val("up_bad_steps", bad, 0);
    check_val("up_top0_sat", get_top(0), 16);
    check_val("up_top1_still", get_top(1), 336);
    strobe();
    probe(984, 16, 1'b1);  check_val("top_row_at_0", col_a, 24'hFFFFFF);
    probe(984, 111, 1'b1); check_val("bot_row_at_0", col_a, 24'hFFFFFF);
    probe(984, 112, 1'b1); check_val("below_at_0", col_a, 24'h000000);
    probe(984, 15, 1'b1);  check_val("border_above", col_a, 24'h00FFFF);

    // Both held: no move; then down alone steps 1
    @(negedge clk); up_a = 2'b01; dn_a = 2'b01;
    repeat (40) @(negedge clk);
    check_val("both_no_move", get_top(0), 16);
    up_a = '0;
    wait_change(0, 16, cur, ok);
    check_val("down_wait_ok", ok, 1);
    check_val("down_step", int'(cur) - 16, 1);

    // Tick and frameStrobe in the same cycle: display keeps the pre-update position
    @(negedge clk);
    @(negedge clk);
    old = get_top(0);
    fs = 1'b1;
    @(negedge clk); fs = 1'b0;
    @(negedge clk);
    check_val("coinc_moved", get_top(0), int'(old) + 1);
    dn_a = '0;
    probe(984, int'(old), 1'b1);      check_val("coinc_top_row", col_a, 24'hFFFFFF);
    probe(984, int'(old) - 1, 1'b1);  check_val("coinc_above", col_a, 24'h000000);
    probe(984, int'(old) + 95, 1'b1); check_val("coinc_last_row", col_a, 24'hFFFFFF);
    probe(984, int'(old) + 96, 1'b1); check_val("coinc_below", col_a, 24'h000000);

    // Acceleration: hold down from 320
    @(negedge clk); dn_b = 2'b01;
    prev = get_top(2); changes = 0; bad = 0; peak = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      cur = get_top(2);
      if (cur != prev) begin
        d = int'(cur) - int'(prev);
        if (changes < 8) check_val($sformatf("accel_step%0d", changes), d, accel_exp[changes]);
        else if (d != 4) bad++;
        changes++;
        prev = cur;
      end
      if (int'(cur) > peak) peak = int'(cur);
    end
    check_val("accel_moves", changes, 83);
    check_val("accel_bad_steps", bad, 0);
    check_val("accel_final", get_top(2), 656);
    check_val("accel_peak", peak, 656);

    // Reverse to up: restart at 1 and accelerate to 3, then reverse again
    dn_b = '0; up_b = 2'b01;
    prev = get_top(2);
    for (int k = 0; k < 5; k++) begin
      wait_change(2, prev, cur, ok);
      check_val($sformatf("rev_up_step%0d", k), int'(cur) - int'(prev), up_exp[k]);
      prev = cur;
    end
    up_b = '0; dn_b = 2'b01;
    wait_change(2, prev, cur, ok);
    check_val("rev_dn_step", int'(cur) - int'(prev), 1);
    prev = cur;
    wait_change(2, prev, cur, ok);
    check_val("dn_step1", int'(cur) - int'(prev), 1);
    prev = cur;
    wait_change(2, prev, cur, ok);
    check_val("dn_step2", int'(cur) - int'(prev), 2);
    prev = cur;
    up_b = 2'b01;
    repeat (40) @(negedge clk);
    check_val("b_both_no_move", get_top(2), prev);
    up_b = '0;
    wait_change(2, prev, cur, ok);
    check_val("b_after_both", int'(cur) - int'(prev), 1);
    dn_b = '0;

    // Reset mid-frame
    @(negedge clk); x = 11'd8; y = 11'd100; vis = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_col", col_a, 24'h00FFFF);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_col_a", col_a, 0);
    check_val("mid_rst_brd_a", bh_a, 0);
    check_val("mid_rst_hit_a", hit_a, 0);
    check_val("mid_rst_top0_a", get_top(0), 336);
    check_val("mid_rst_top1_a", get_top(1), 336);
    check_val("mid_rst_top0_b", get_top(2), 336);
    check_val("mid_rst_col_b", col_b, 0);
    @(negedge clk); rst_n = 1'b1; x = '0; y = '0; vis = 1'b0;
    probe(984, 336, 1'b1);
    check_val("post_rst_disp_a", col_a, 24'hFFFFFF);
    check_val("post_rst_disp_b", col_b, 24'hFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
